console_writer: RTL



---
 rtl/console_writer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/console_writer.sv
// console_writer: write side of the text-console VRAM.
// Takes a valid/ready byte stream, keeps a cursor on a screenW x screenH grid,
// writes printable codes into VRAM, handles CR/LF/BS/FF and blanks the line
// the cursor moves onto (or the whole screen on FF / reset).
module console_writer #(
  parameter int         screenW        = 40,
  parameter int         screenH        = 30,
  parameter logic [7:0] blank          = 8'h20,
  parameter bit         clear_on_reset = 1'b1
) (
  input  logic        px_clk,
  input  logic        reset_n,
  input  logic [7:0]  char_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [10:0] addr_vram,
  output logic [7:0]  data_vram,
  output logic        we_vram,
  output logic [5:0]  cursor_x,
  output logic [4:0]  cursor_y
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLRLINE = 2'd1,
    CLRALL  = 2'd2
  } state_t;

  localparam state_t      RESET_STATE = clear_on_reset ? CLRALL : IDLE;
  localparam logic [5:0]  LAST_COL    = 6'(screenW - 1);
  localparam logic [4:0]  LAST_ROW    = 5'(screenH - 1);
  localparam logic [10:0] ROW_LEN     = 11'(screenW);
  localparam logic [10:0] LAST_CELL   = 11'(screenW * screenH - 1);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  // First VRAM address of a row; never exceeds the last row's start.
  function automatic logic [10:0] row_base(input logic [4:0] row);
    row_base = {6'd0, row} * ROW_LEN;
  endfunction

  state_t      state, state_nx;
  logic [10:0] clr_cnt, clr_cnt_nx;
  logic [10:0] clr_base, clr_base_nx;
  logic [5:0]  x_nx;
  logic [4:0]  y_nx;
  logic        we_nx;
  logic [10:0] addr_nx;
  logic [7:0]  data_nx;
  logic        ready_nx;
  logic        accept;
  logic        row_adv;
  logic [10:0] cell_addr;

  assign accept    = valid_i & ready_o;
  assign cell_addr = row_base(cursor_y) + {5'd0, cursor_x};

  // Next-state, cursor and VRAM-write decode; everything lands in registers.
  always_comb begin
    state_nx    = state;
    clr_cnt_nx  = clr_cnt;
    clr_base_nx = clr_base;
    x_nx        = cursor_x;
    y_nx        = cursor_y;
    we_nx       = 1'b0;
    addr_nx     = addr_vram;
    data_nx     = data_vram;
    row_adv     = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          case (char_i)
            CH_LF: begin
              x_nx    = 6'd0;
              row_adv = 1'b1;
            end
            CH_CR: begin
              x_nx = 6'd0;
            end
            CH_BS: begin
              if (cursor_x != 6'd0) begin
                x_nx    = cursor_x - 6'd1;
                we_nx   = 1'b1;
                addr_nx = cell_addr - 11'd1;
                data_nx = blank;
              end else begin
                x_nx = cursor_x;
              end
            end
            CH_FF: begin
              x_nx       = 6'd0;
              y_nx       = 5'd0;
              clr_cnt_nx = 11'd0;
              state_nx   = CLRALL;
            end
            default: begin
              if (char_i >= 8'h20 && char_i <= 8'h7E) begin
                we_nx   = 1'b1;
                addr_nx = cell_addr;
                data_nx = char_i;
                if (cursor_x == LAST_COL) begin
                  x_nx    = 6'd0;
                  row_adv = 1'b1;
                end else begin
                  x_nx = cursor_x + 6'd1;
                end
              end else begin
                // Unsupported code: swallowed without effect.
                x_nx = cursor_x;
              end
            end
          endcase

          // Moving to a new row (wrapping to the top) always blanks that row.
          if (row_adv) begin
            y_nx        = (cursor_y == LAST_ROW) ? 5'd0 : cursor_y + 5'd1;
            clr_base_nx = row_base(y_nx);
            clr_cnt_nx  = 11'd0;
            state_nx    = CLRLINE;
          end else begin
            clr_base_nx = clr_base_nx;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      CLRLINE: begin
        we_nx   = 1'b1;
        addr_nx = clr_base + clr_cnt;
        data_nx = blank;
        if (clr_cnt == ROW_LEN - 11'd1) begin
          state_nx = IDLE;
        end else begin
          clr_cnt_nx = clr_cnt + 11'd1;
        end
      end
      CLRALL: begin
        we_nx   = 1'b1;
        addr_nx = clr_cnt;
        data_nx = blank;
        if (clr_cnt == LAST_CELL) begin
          state_nx = IDLE;
        end else begin
          clr_cnt_nx = clr_cnt + 11'd1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    ready_nx = (state_nx == IDLE);
  end

  // State, clear counter and all registered outputs.
  always_ff @(posedge px_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RESET_STATE;
      clr_cnt   <= 11'd0;
      clr_base  <= 11'd0;
      cursor_x  <= 6'd0;
      cursor_y  <= 5'd0;
      we_vram   <= 1'b0;
      addr_vram <= 11'd0;
      data_vram <= 8'd0;
      ready_o   <= 1'b0;
    end else begin
      state     <= state_nx;
      clr_cnt   <= clr_cnt_nx;
      clr_base  <= clr_base_nx;
      cursor_x  <= x_nx;
      cursor_y  <= y_nx;
      we_vram   <= we_nx;
      addr_vram <= addr_nx;
      data_vram <= data_nx;
      ready_o   <= ready_nx;
    end
  end

endmodule
